seq_pattern_tx: RTL

Serial pattern transmitter that emits a programmable WIDTH-bit pattern MSB-first on a single-bit line, optionally repeated back-to-back with a configurable idle gap between copies. It is the stimulus/transmit side of the serial sequence-detection path: it drives the bit stream (default pattern 1010) that downstream Moore detectors consume. A request is accepted through a valid/ready handshake, and all outputs are registered Moore outputs.

---
 rtl/seq_pattern_tx_if.sv | 26 ++
 rtl/seq_pattern_tx.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx_if.sv
// Request/serial-output bundle for seq_pattern_tx.
// "repeat" is a reserved word in SystemVerilog, so the repeat field is carried as repeat_n.
interface seq_pattern_tx_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] pattern;
    logic [REP_W-1:0] repeat_n;
    logic             dout;
    logic             dout_valid;
    logic             frame_end;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, pattern, repeat_n,
        input  start_ready, dout, dout_valid, frame_end, busy, done
    );

    modport slave (
        input  start_valid, pattern, repeat_n,
        output start_ready, dout, dout_valid, frame_end, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a WIDTH-bit pattern MSB-first, repeat_n+1 copies,
// with GAP idle cycles between copies. All outputs are registered Moore outputs.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_tx_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [BW-1:0] PRE_LAST = BW'(WIDTH - 2);
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [WIDTH-1:0]  reload_q, reload_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [REP_W-1:0]  copy_q, copy_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              frame_end_q, frame_end_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;

    // Each branch computes the outputs for the *next* cycle, so dout always
    // reflects the bit selected one cycle earlier and no output is combinational.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        reload_d     = reload_q;
        bit_cnt_d    = bit_cnt_q;
        copy_d       = copy_q;
        gap_d        = gap_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        frame_end_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        ready_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.start_valid && ready_q) begin
                    state_d      = S_SHIFT;
                    reload_d     = bus.pattern;
                    shift_d      = bus.pattern << 1;
                    bit_cnt_d    = '0;
                    copy_d       = bus.repeat_n;
                    dout_d       = bus.pattern[WIDTH-1];
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                    ready_d      = 1'b0;
                end
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (bit_cnt_q != LAST_BIT) begin
                    dout_d       = shift_q[WIDTH-1];
                    dout_valid_d = 1'b1;
                    shift_d      = shift_q << 1;
                    bit_cnt_d    = bit_cnt_q + BW'(1);
                    frame_end_d  = (bit_cnt_q == PRE_LAST);
                end else if (copy_q != '0) begin
                    copy_d    = copy_q - REP_W'(1);
                    bit_cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        dout_d       = reload_q[WIDTH-1];
                        dout_valid_d = 1'b1;
                        shift_d      = reload_q << 1;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q != '0) begin
                    gap_d = gap_q - GW'(1);
                end else begin
                    state_d      = S_SHIFT;
                    dout_d       = reload_q[WIDTH-1];
                    dout_valid_d = 1'b1;
                    shift_d      = reload_q << 1;
                    bit_cnt_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            reload_q     <= '0;
            bit_cnt_q    <= '0;
            copy_q       <= '0;
            gap_q        <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            frame_end_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            reload_q     <= reload_d;
            bit_cnt_q    <= bit_cnt_d;
            copy_q       <= copy_d;
            gap_q        <= gap_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_end_q  <= frame_end_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.start_ready = ready_q;
endmodule
